regfile_write_arbiter: RTL and testbench

//  Sequences and shares the single write port (we3/wa3/wd3) of the register file.
//  Two requesters, A (datapath writeback) and B (debug/switch load), use valid/ready handshakes.

---
 rtl/regfile_write_arbiter_if.sv | 33 +++
 rtl/regfile_write_arbiter.sv | 111 +++++++++++
 tb/tb_regfile_write_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Write-port bundle between the two requesters, the arbiter and the register file.
interface regfile_write_arbiter_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3
) ();

  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic              rf_we3;
  logic [ADDR_W-1:0] rf_wa3;
  logic [DATA_W-1:0] rf_wd3;

  modport slave (
    input  a_valid, a_addr, a_data,
    input  b_valid, b_addr, b_data,
    output a_ready, b_ready,
    output rf_we3, rf_wa3, rf_wd3
  );

  modport master (
    output a_valid, a_addr, a_data,
    output b_valid, b_addr, b_data,
    input  a_ready, b_ready,
    input  rf_we3, rf_wa3, rf_wd3
  );

endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between two requesters (round-robin) and
// zeroes the whole file after reset or on clear_req before serving any request.
module regfile_write_arbiter #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 3,
  parameter bit          PROTECT_R0 = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear_req,
  regfile_write_arbiter_if.slave  bus,
  output logic                    busy,
  output logic                    last_b
);

  localparam int unsigned NUM_REGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic              rf_we3_q;
  logic [ADDR_W-1:0] rf_wa3_q;
  logic [DATA_W-1:0] rf_wd3_q;
  logic              last_b_q;

  logic grant_a;
  logic grant_b;

  // Round-robin grant; on contention the requester not served last wins.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state_q == RUN && !clear_req) begin
      if (bus.a_valid && bus.b_valid) begin
        grant_a = last_b_q;
        grant_b = !last_b_q;
      end else begin
        grant_a = bus.a_valid;
        grant_b = bus.b_valid;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      rf_we3_q  <= 1'b0;
      rf_wa3_q  <= '0;
      rf_wd3_q  <= '0;
      last_b_q  <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          if (clear_req) begin
            clr_cnt_q <= '0;
            rf_we3_q  <= 1'b0;
          end else begin
            rf_we3_q <= 1'b1;
            rf_wa3_q <= clr_cnt_q;
            rf_wd3_q <= '0;
            if (clr_cnt_q == LAST_ADDR) begin
              state_q   <= RUN;
              clr_cnt_q <= '0;
            end else begin
              clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
            end
          end
        end
        RUN: begin
          if (clear_req) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
            rf_we3_q  <= 1'b0;
          end else if (grant_a) begin
            rf_we3_q <= !(PROTECT_R0 && bus.a_addr == '0);
            rf_wa3_q <= bus.a_addr;
            rf_wd3_q <= bus.a_data;
            last_b_q <= 1'b0;
          end else if (grant_b) begin
            rf_we3_q <= !(PROTECT_R0 && bus.b_addr == '0);
            rf_wa3_q <= bus.b_addr;
            rf_wd3_q <= bus.b_data;
            last_b_q <= 1'b1;
          end else begin
            rf_we3_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= CLEAR;
          clr_cnt_q <= '0;
          rf_we3_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.a_ready = grant_a;
  assign bus.b_ready = grant_b;
  assign bus.rf_we3  = rf_we3_q;
  assign bus.rf_wa3  = rf_wa3_q;
  assign bus.rf_wd3  = rf_wd3_q;
  assign busy        = (state_q == CLEAR);
  assign last_b      = last_b_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench: stimulus pushes expected register-file writes into a queue,
// a negedge monitor pops one entry for every rf_we3 pulse and compares it.
module tb_regfile_write_arbiter;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 3;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic clk;
  logic rst_n;
  logic clear_req;
  logic busy;
  logic last_b;

  int total;
  int bad;
  wr_t exp_q[$];

  regfile_write_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_write_arbiter #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .PROTECT_R0(1'b1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_req(clear_req),
    .bus      (bus.slave),
    .busy     (busy),
    .last_b   (last_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic push_clear(input int n);
    for (int i = 0; i < n; i++) push_wr(ADDR_W'(i), '0);
  endtask

  // Monitor: every write the DUT issues must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.rf_we3 === 1'b1) begin
      wr_t e;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write actual=%0h/%0h required=none", bus.rf_wa3, bus.rf_wd3);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(bus.rf_wa3), 32'(e.addr));
        chk("wr_data", 32'(bus.rf_wd3), 32'(e.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Hand-computed grant order for test 3 (1 = B).
  logic grant_tbl [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    total       = 0;
    bad         = 0;
    rst_n       = 1'b0;
    clear_req   = 1'b0;
    bus.a_valid = 1'b1;
    bus.a_addr  = 3'd3;
    bus.a_data  = 8'h00;
    bus.b_valid = 1'b1;
    bus.b_addr  = 3'd2;
    bus.b_data  = 8'h00;

    // Reset state, with both valids high to prove readies are gated.
    #12;
    chk("rst_busy",   32'(busy),        32'd1);
    chk("rst_we3",    32'(bus.rf_we3),  32'd0);
    chk("rst_wa3",    32'(bus.rf_wa3),  32'd0);
    chk("rst_wd3",    32'(bus.rf_wd3),  32'd0);
    chk("rst_last_b", 32'(last_b),      32'd0);
    chk("rst_a_rdy",  32'(bus.a_ready), 32'd0);
    chk("rst_b_rdy",  32'(bus.b_ready), 32'd0);

    // Test 1: zeroing pass of 8 writes after release.
    @(negedge clk);
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    push_clear(8);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("clr_busy", 32'(busy), 32'd1);
      step();
    end
    chk("run_busy", 32'(busy), 32'd0);

    // Test 2: single A request.
    bus.a_valid = 1'b1;
    bus.a_addr  = 3'd3;
    bus.a_data  = 8'hA5;
    #1;
    chk("t2_a_rdy", 32'(bus.a_ready), 32'd1);
    chk("t2_b_rdy", 32'(bus.b_ready), 32'd0);
    push_wr(3'd3, 8'hA5);
    step();
    bus.a_valid = 1'b0;
    chk("t2_last_b", 32'(last_b), 32'd0);
    step();

    // Test 3: contention alternates starting with B.
    bus.a_valid = 1'b1;
    bus.a_addr  = 3'd1;
    bus.a_data  = 8'h11;
    bus.b_valid = 1'b1;
    bus.b_addr  = 3'd2;
    bus.b_data  = 8'h22;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t3_a_rdy", 32'(bus.a_ready), 32'(!grant_tbl[k]));
      chk("t3_b_rdy", 32'(bus.b_ready), 32'(grant_tbl[k]));
      if (grant_tbl[k]) push_wr(3'd2, 8'h22);
      else              push_wr(3'd1, 8'h11);
      step();
      chk("t3_last_b", 32'(last_b), 32'(grant_tbl[k]));
    end
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    step();

    // Test 4: write to protected register 0 is accepted but suppressed.
    bus.b_valid = 1'b1;
    bus.b_addr  = 3'd0;
    bus.b_data  = 8'hFF;
    #1;
    chk("t4_b_rdy", 32'(bus.b_ready), 32'd1);
    step();
    bus.b_valid = 1'b0;
    chk("t4_we3",    32'(bus.rf_we3), 32'd0);
    chk("t4_last_b", 32'(last_b),     32'd1);
    step();

    // Test 5: clear_req in the middle of an A stream.
    bus.a_valid = 1'b1;
    bus.a_addr  = 3'd5;
    bus.a_data  = 8'h3C;
    #1;
    chk("t5_a_rdy0", 32'(bus.a_ready), 32'd1);
    push_wr(3'd5, 8'h3C);
    step();
    clear_req = 1'b1;
    #1;
    chk("t5_a_rdy_clr", 32'(bus.a_ready), 32'd0);
    chk("t5_b_rdy_clr", 32'(bus.b_ready), 32'd0);
    push_clear(8);
    step();
    clear_req = 1'b0;
    chk("t5_we3_clr", 32'(bus.rf_we3), 32'd0);
    for (int k = 0; k < 8; k++) begin
      chk("t5_busy",  32'(busy),        32'd1);
      chk("t5_a_blk", 32'(bus.a_ready), 32'd0);
      step();
    end
    chk("t5_busy_end", 32'(busy),        32'd0);
    chk("t5_a_rdy1",   32'(bus.a_ready), 32'd1);
    push_wr(3'd5, 8'h3C);
    step();
    bus.a_valid = 1'b0;
    step();

    // Test 6: reset while the pass is at clr_cnt=5.
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    push_clear(5);
    for (int k = 0; k < 5; k++) step();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_we3_rst",  32'(bus.rf_we3), 32'd0);
    chk("t6_busy_rst", 32'(busy),       32'd1);
    push_clear(8);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) step();
    chk("t6_busy_end", 32'(busy), 32'd0);
    step();
    step();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
